// File: rtl/mul_sched_pkg.sv
// Purpose : shared types for the limb-array multiplier scheduler (FSM states, counter sizing, limb arrays).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Default geometry of the shared multiplier.
    localparam int NUM_ELEMENTS_DEF = 17;
    localparam int BIT_LEN_DEF      = 17;
    localparam int MUL_LATENCY_DEF  = 0;

    // Latency counter width: enough to hold MUL_LATENCY, never narrower than 1 bit.
    function automatic int cnt_width(input int latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(MUL_LATENCY_DEF);

    // Limb arrays as seen by the multiplier: element 0 is the least significant limb.
    typedef logic [BIT_LEN_DEF-1:0]            limb_t;
    typedef limb_t [NUM_ELEMENTS_DEF-1:0]      operand_t;
    typedef limb_t [2*NUM_ELEMENTS_DEF-1:0]    result_t;

endpackage

// File: rtl/mul_sched_arb.sv
// Purpose : one-hot request arbiter; round-robin when MUL_SCHED_RR_EN is defined, else lowest index wins.
// Latency : grant is combinational from req/en; the pointer moves on the edge where accept is high.
// Backpressure: grant forced to zero while en is low; pointer never moves without accept.
// Ports   : req (request vector), en (arbitration allowed), accept (grant was taken), gnt (one-hot grant).
module mul_sched_arb
    import mul_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic               accept,
    output logic [NUM_REQ-1:0] gnt
);

`ifdef MUL_SCHED_RR_EN
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] lo_mask;
    logic [NUM_REQ-1:0] hi_req;
    logic [NUM_REQ-1:0] sel;

    // Requests at or above the pointer take precedence; if none, wrap to the
    // full vector. The lowest set bit of the chosen vector is the winner.
    always_comb begin
        lo_mask = (NUM_REQ'(1) << ptr_q) - NUM_REQ'(1);
        hi_req  = req & ~lo_mask;
        sel     = (|hi_req) ? hi_req : req;
        gnt     = en ? (sel & (~sel + NUM_REQ'(1))) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) begin
                    ptr_d = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: isolate the lowest set request bit.
    always_comb begin
        gnt = en ? (req & (~req + NUM_REQ'(1))) : '0;
    end

    logic unused_arb;
    assign unused_arb = ^{clk, rst_n, accept};
`endif

endmodule

// File: rtl/mul_sched.sv
// Purpose : arbitrates NUM_REQ clients onto one shared multiplier, one operation in flight, tagged response.
// Latency : transfer at edge T -> rsp_valid from cycle T+2+MUL_LATENCY; back-to-back spacing MUL_LATENCY+3.
// Backpressure: rsp_ready low holds the response registers and blocks all new grants.
// Ports   : req_* (per-client valid/ready + operands), mul_* (multiplier side), rsp_* (tagged result), busy.
// Config  : define MUL_SCHED_RR_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int NUM_ELEMENTS = NUM_ELEMENTS_DEF,
    parameter int BIT_LEN      = BIT_LEN_DEF,
    parameter int MUL_LATENCY  = MUL_LATENCY_DEF,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [NUM_REQ-1:0]                             req_valid,
    output logic [NUM_REQ-1:0]                             req_ready,
    input  logic [NUM_REQ-1:0][NUM_ELEMENTS-1:0][BIT_LEN-1:0] req_a,
    input  logic [NUM_REQ-1:0][NUM_ELEMENTS-1:0][BIT_LEN-1:0] req_b,
    output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]           mul_a,
    output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]           mul_b,
    output logic                                           mul_valid,
    input  logic [2*NUM_ELEMENTS-1:0][BIT_LEN-1:0]         mul_m,
    output logic                                           rsp_valid,
    input  logic                                           rsp_ready,
    output logic [ID_W-1:0]                                rsp_id,
    output logic [2*NUM_ELEMENTS-1:0][BIT_LEN-1:0]         rsp_m,
    output logic                                           busy
);

    localparam int CNT_W = cnt_width(MUL_LATENCY);

    state_e                                 state_q, state_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic [ID_W-1:0]                        id_q, id_d;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   mul_a_q, mul_a_d;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   mul_b_q, mul_b_d;
    logic [2*NUM_ELEMENTS-1:0][BIT_LEN-1:0] rsp_m_q, rsp_m_d;
    logic                                   rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               accept;

    mul_sched_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .en     (state_q == IDLE),
        .accept (accept),
        .gnt    (gnt)
    );

    // The grant is already a subset of req_valid, so any grant bit is a transfer.
    assign accept = |gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = ID_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)           state_d = WAIT;
            WAIT:    if (cnt_q == '0)      state_d = RESP;
            RESP:    if (rsp_ready)        state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        req_ready = gnt;
        mul_valid = (state_q == WAIT);
        busy      = (state_q != IDLE);
    end

    // Datapath next values: operands and tag latched on transfer, product
    // latched when the latency count has run out.
    always_comb begin
        cnt_d       = cnt_q;
        id_d        = id_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_m_d     = rsp_m_q;
        rsp_valid_d = (state_d == RESP);
        if (state_q == IDLE && accept) begin
            mul_a_d = req_a[gnt_idx];
            mul_b_d = req_b[gnt_idx];
            id_d    = gnt_idx;
            cnt_d   = CNT_W'(MUL_LATENCY);
        end else if (state_q == WAIT) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                rsp_m_d = mul_m;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            id_q        <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_m_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_m_q     <= rsp_m_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_m     = rsp_m_q;
    assign rsp_id    = id_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: doc/mul_sched.md
# mul_sched

Request scheduler for the shared limb-array multiplier. Up to NUM_REQ clients present limb-vector operand pairs through valid/ready handshakes. The block arbitrates between them, registers the winning operands onto the multiplier inputs and waits a fixed number of cycles for the product. It then returns the NUM_ELEMENTS*2-limb result, tagged with the requester index, on a single response channel. One operation is in flight at a time.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- NUM_ELEMENTS, 17, limbs per operand
- BIT_LEN, 17, bits per limb
- MUL_LATENCY, 0, cycles from operand-register update to valid `mul_m`; 0 means the multiplier is purely combinational
- ID_W, $clog2(NUM_REQ), width of requester tag

Ports:
- clk, in, 1, sole clock, rising edge
- rst_n, in, 1, reset: asynchronous assert, active-low
- req_valid, in, [NUM_REQ], operand pair valid per requester
- req_ready, out, [NUM_REQ], one-hot grant; transfer occurs on valid&ready
- req_a, in, [NUM_REQ][NUM_ELEMENTS] x BIT_LEN, A limbs per requester
- req_b, in, [NUM_REQ][NUM_ELEMENTS] x BIT_LEN, B limbs per requester
- mul_a, out, [NUM_ELEMENTS] x BIT_LEN, registered A to the multiplier
- mul_b, out, [NUM_ELEMENTS] x BIT_LEN, registered B to the multiplier
- mul_valid, out, 1, high while operands on mul_a/mul_b are live (WAIT state)
- mul_m, in, [NUM_ELEMENTS*2] x BIT_LEN, product limbs from the multiplier
- rsp_valid, out, 1, result available
- rsp_ready, in, 1, consumer accepts result
- rsp_id, out, ID_W, index of the requester that owns rsp_m
- rsp_m, out, [NUM_ELEMENTS*2] x BIT_LEN, registered product
- busy, out, 1, state != IDLE

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready is the arbiter's one-hot grant over req_valid. The grant is combinational; all zeros if no request.
  - On transfer: capture req_a/req_b of the winner into mul_a/mul_b, capture its index into the id register, load cnt=MUL_LATENCY, and go to WAIT.
- WAIT:
  - req_ready is all zeros and mul_valid=1.
  - If cnt!=0, decrement cnt.
  - If cnt==0, capture mul_m into rsp_m and go to RESP.
- RESP:
  - rsp_valid=1; rsp_m and rsp_id are held stable while rsp_ready=0.
  - On rsp_ready=1, go to IDLE. No new request is accepted in this same cycle.
- mul_a/mul_b keep their last value outside WAIT; they are not cleared.
- The arbiter pointer advances only on a transfer, never on an idle cycle.
- A requester that drops req_valid before it is granted simply loses its turn; there is no error.
- Reset values (also on any mid-operation reset):
  - state=IDLE, cnt=0, rr pointer=0, id register=0.
  - mul_a, mul_b and rsp_m are all zero.
  - rsp_valid=0, mul_valid=0, busy=0.
  - An in-flight result is discarded.
- Width rule: the block does not do any arithmetic on limbs. mul_m is copied bit-exact into rsp_m.

## Timing
- Transfer at edge T:
  - state=WAIT from T+1.
  - rsp_m is captured at edge T+1+MUL_LATENCY.
  - rsp_valid is high from cycle T+2+MUL_LATENCY.
- Minimum spacing between transfers is MUL_LATENCY+3 cycles, reached with rsp_ready held at 1.
- req_ready depends combinationally on req_valid and the state. Requesters must not make req_valid depend on req_ready.
- rsp_valid, rsp_id and rsp_m are driven directly from registers.

## Configuration
- MUL_SCHED_RR_EN defined:
  - Round-robin arbitration. The search starts at pointer p, and after a grant to index g, p becomes (g+1) mod NUM_REQ.
  - Starvation-free: any requester holding req_valid is granted within NUM_REQ transfers.
- Not defined:
  - Fixed priority: the lowest index wins.
  - The rr pointer register is not built.

## Structure
- Package mul_sched_pkg holds:
  - the state enum (IDLE, WAIT, RESP)
  - the cnt width localparam, $clog2(MUL_LATENCY+1) with a minimum of 1
  - the limb/result array typedefs shared with the multiplier
- One sub-module, mul_sched_arb:
  - Inputs: request vector, enable (IDLE) and accept strobe.
  - Output: one-hot grant.
  - Contains the pointer under MUL_SCHED_RR_EN.

## Test plan
Bench settings: NUM_REQ=4, NUM_ELEMENTS=2, BIT_LEN=17, MUL_LATENCY=2. The bench uses a behavioural multiplier model with matching latency.
1. Single request: req 2 with a={5,0}, b={7,0} and rsp_ready=1 → req_ready=4'b0100 for one cycle; rsp_valid goes high 4 cycles after the transfer with rsp_id=2 and rsp_m={35,0,0,0}; busy falls 1 cycle after that.
2. All four requests held valid, with MUL_SCHED_RR_EN → grant order 0,1,2,3,0. Without the macro → 0,0,0… (requester 0 is re-granted whenever it stays valid).
3. Response backpressure: hold rsp_ready=0 for 10 cycles → rsp_valid stays 1, rsp_m/rsp_id are unchanged, req_ready=0 throughout, and there is no second transfer.
4. MUL_LATENCY=0 build: a={1,1}, b={0x1FFFF,0} → rsp_m equals the model product, with rsp_valid 2 cycles after the transfer.
5. Assert rst_n=0 asynchronously mid-WAIT → all outputs are at reset values before the next edge; after release, the original request is re-granted and completes normally.
6. Requester 1 drops req_valid while requester 0 is in flight → no transfer for 1; the next grant goes to the next valid index.
